pending_encoder32_5: RTL and testbench
======================================

# pending_encoder32_5

Serial 32-to-5 request encoder: the inverse of the 5-to-32 enable decoder used for register and write-enable selection. It accepts a 32-bit multi-hot vector, such as a set of pending register-write or interrupt lines. It then emits the 5-bit index of every set bit, one per handshake, lowest index first. It sits between request-collecting logic and any consumer that takes one register/line number at a time, for example a register-file scrub or writeback sequencer.

## Interface
Parameters:
- WIDTH, 32, number of request lines. Must be a power of two.
- IDX_W, 5, index width; always $clog2(WIDTH).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- load_valid  in  1  load_vec is offered.
- load_ready  out  1  block can accept a vector this cycle.
- load_vec  in  WIDTH  multi-hot request vector.
- idx_valid  out  1  idx is valid.
- idx_ready  in  1  consumer accepts idx this cycle.
- idx  out  IDX_W  index of the lowest remaining set bit.
- last  out  1  idx is the final index of the current vector; qualified by idx_valid.
- remaining  out  IDX_W+1  set bits still pending, including the one on idx.
- busy  out  1  high whenever the state is EMIT.

## Operation
- Internal registers: state (IDLE/EMIT), pending[WIDTH-1:0], remaining[IDX_W:0].
- IDLE behaviour:
  - load_ready=1, idx_valid=0.
  - On load_valid and load_vec != 0: pending <= load_vec, remaining <= popcount(load_vec), state <= EMIT.
  - On load_valid and load_vec == 0: the vector is accepted and dropped. State stays IDLE and nothing is emitted.
- EMIT behaviour:
  - load_ready=0, idx_valid=1.
  - idx = position of the lowest set bit of pending. Bit 0 has the highest priority.
  - last = (remaining == 1).
  - On idx_ready: clear pending[idx] and decrement remaining.
  - If last was set on that transfer, state <= IDLE.
  - Without idx_ready: idx, last and remaining are held stable (AXI-style). Payload must not change while idx_valid=1 and idx_ready=0.
- Input changes: load_vec and load_valid are ignored in EMIT. They have no effect on pending.
- Invariant: in EMIT, pending != 0 and remaining == popcount(pending).
- Outputs are combinational from registered state only. There is no combinational path from idx_ready to idx_valid, and none from load_valid to load_ready.

## Timing
- Reset values: state=IDLE, pending=0, remaining=0, load_ready=1, idx_valid=0, idx=0, last=0, busy=0.
- Load-to-first-index latency: load accepted at edge N; idx_valid=1 in cycle N+1.
- Throughput: one index per cycle while idx_ready is held high. A vector with k set bits finishes k cycles after first idx_valid.
- Bubble between vectors: the final transfer returns the block to IDLE. load_ready is high the following cycle, so back-to-back vectors have one idle cycle between them.
- WIDTH=32 boundaries:
  - All-ones vector emits 0..31 over 32 transfers; remaining starts at 32 (6-bit).
  - Single bit 31 emits idx=31 with last=1 on its first cycle.
- Reset mid-operation: reset wins over any simultaneous handshake. On the next cycle the block is in reset state, and pending indices are discarded without output.

## Structure
- Package encoder_pkg holds:
  - WIDTH/IDX_W defaults.
  - typedef enum logic {IDLE, EMIT} enc_state_t.
  - A popcount function on WIDTH bits.
- Sub-module priority_enc32_5: purely combinational.
  - Inputs: in[WIDTH-1:0].
  - Outputs: out[IDX_W-1:0] (lowest set bit) and any (in != 0).
  - Built hierarchically from 8-to-3 priority encoders plus a 4-to-2 group select, mirroring the decoder tree.
- Top level: the FSM, the pending/remaining registers, and one priority_enc32_5 instance on pending.

## Test plan
- Reset: hold reset 2 cycles during EMIT of 32'hFFFF_FFFF -> next cycle idx_valid=0, load_ready=1, remaining=0, busy=0.
- Basic sequence: load 32'h8000_0025 with idx_ready=1 -> idx 0,2,5,31 on consecutive cycles. remaining reads 4,3,2,1; last only on 31. load_ready=1 the cycle after.
- Backpressure: load 32'h0000_0003, idx_ready low 3 cycles -> idx=0 and remaining=2 held stable. Then ready high -> idx=0, then idx=1 with last=1.
- Zero and ignored loads:
  - Load 32'h0 -> no idx_valid ever, state stays IDLE.
  - load_valid=1 during EMIT -> pending unchanged, new vector not captured.
- Full vector: load 32'hFFFF_FFFF with random idx_ready -> exactly 32 transfers, indices 0..31 in order, remaining starts at 32, last on idx 31 only.
- Back-to-back: load 32'h0000_0010, then hold load_valid high with 32'h4000_0000 -> idx=4 (last), one IDLE cycle, then idx=30 (last).

Source files
------------

// File: rtl/pending_encoder32_5_pkg.sv
// Shared defaults, state encoding and popcount helper for the serial
// 32-to-5 request encoder.
package encoder_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int IDX_W_DEF = $clog2(WIDTH_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } enc_state_t;

    function automatic logic [IDX_W_DEF:0] popcount(input logic [WIDTH_DEF-1:0] vec);
        logic [IDX_W_DEF:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH_DEF; i++) begin
            cnt = cnt + {{IDX_W_DEF{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/pending_encoder32_5_if.sv
// Load/index handshake bundle between the request collector, the encoder
// and the index consumer.
interface pending_encoder32_5_if
    import encoder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) ();

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_vec;
    logic             idx_valid;
    logic             idx_ready;
    logic [IDX_W-1:0] idx;
    logic             last;
    logic [IDX_W:0]   remaining;
    logic             busy;

    modport slave (
        input  load_valid,
        input  load_vec,
        input  idx_ready,
        output load_ready,
        output idx_valid,
        output idx,
        output last,
        output remaining,
        output busy
    );

    modport master (
        output load_valid,
        output load_vec,
        output idx_ready,
        input  load_ready,
        input  idx_valid,
        input  idx,
        input  last,
        input  remaining,
        input  busy
    );

endinterface

// File: rtl/pending_encoder32_5_priority_enc.sv
// Combinational 32-to-5 lowest-set-bit encoder: four 8-to-3 group encoders
// and a 4-to-2 group select, the mirror of the 5-to-32 decoder tree.
module priority_enc32_5
    import encoder_pkg::*;
(
    input  logic [WIDTH_DEF-1:0] in,
    output logic [IDX_W_DEF-1:0] out,
    output logic                 any
);

    localparam int N_GRP = WIDTH_DEF / 8;

    function automatic logic [2:0] enc8(input logic [7:0] vec);
        logic [2:0] pos;
        pos = '0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) pos = 3'(i);
        end
        return pos;
    endfunction

    logic [N_GRP-1:0] grp_any;
    logic [2:0]       grp_idx [N_GRP];
    logic [1:0]       grp_sel;

    for (genvar g = 0; g < N_GRP; g++) begin : g_grp
        assign grp_any[g] = |in[8*g +: 8];
        assign grp_idx[g] = enc8(in[8*g +: 8]);
    end

    // Lowest populated group wins, matching bit-0-first priority.
    always_comb begin
        grp_sel = '0;
        for (int g = N_GRP - 1; g >= 0; g--) begin
            if (grp_any[g]) grp_sel = 2'(g);
        end
    end

    assign out = {grp_sel, grp_idx[grp_sel]};
    assign any = |grp_any;

endmodule

// File: rtl/pending_encoder32_5.sv
// Serial request encoder: captures a multi-hot vector and hands out the
// index of each set bit, lowest first, one per idx handshake.
//
// state | meaning
// IDLE  | ready for a new vector, nothing pending
// EMIT  | presenting the lowest pending index until the last one is taken
module pending_encoder32_5
    import encoder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic clk,
    input  logic reset,
    pending_encoder32_5_if.slave bus
);

    localparam logic [IDX_W:0] REM_ONE = (IDX_W + 1)'(1);

    enc_state_t       state, state_nxt;
    logic [WIDTH-1:0] pending, pending_nxt;
    logic [IDX_W:0]   remaining, remaining_nxt;

    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             load_ready;
    logic             idx_valid;

    priority_enc32_5 u_prio (
        .in  (pending),
        .out (enc_idx),
        .any (enc_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= '0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            remaining <= remaining_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pending_nxt   = pending;
        remaining_nxt = remaining;
        load_ready    = 1'b0;
        idx_valid     = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                // An all-zero vector is accepted but produces no indices.
                if (bus.load_valid && (|bus.load_vec)) begin
                    pending_nxt   = bus.load_vec;
                    remaining_nxt = popcount(bus.load_vec);
                    state_nxt     = EMIT;
                end
            end
            EMIT: begin
                idx_valid = 1'b1;
                if (bus.idx_ready) begin
                    pending_nxt[enc_idx] = 1'b0;
                    remaining_nxt        = remaining - REM_ONE;
                    if (remaining == REM_ONE) state_nxt = IDLE;
                end
                // Cannot happen while pending and remaining agree; recover
                // to IDLE rather than emit a phantom index forever.
                if (!enc_any) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.load_ready = load_ready;
    assign bus.idx_valid  = idx_valid;
    assign bus.idx        = (state == EMIT) ? enc_idx : '0;
    assign bus.last       = (state == EMIT) && (remaining == REM_ONE);
    assign bus.remaining  = remaining;
    assign bus.busy       = (state == EMIT);

endmodule

// File: tb/tb_pending_encoder32_5.sv
// Scoreboard bench for pending_encoder32_5: directed loads push expected
// transfers, a negedge monitor pops and compares on every idx handshake.
module tb_pending_encoder32_5;

    typedef struct packed {
        logic [4:0] idx;
        logic       last;
        logic [5:0] rem;
    } exp_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   n_xfer = 0;
    exp_t exp_q[$];

    pending_encoder32_5_if ifc ();

    pending_encoder32_5 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input bit l, input int r);
        exp_t e;
        e.idx  = 5'(i);
        e.last = l;
        e.rem  = 6'(r);
        exp_q.push_back(e);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_idx_valid"}, int'(ifc.idx_valid), 0);
        chk({name, "_load_ready"}, int'(ifc.load_ready), 1);
        chk({name, "_busy"}, int'(ifc.busy), 0);
    endtask

    // Monitor: every accepted index must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && ifc.idx_valid && ifc.idx_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                chk("unexpected_idx", int'(ifc.idx), -1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_idx", int'(ifc.idx), int'(e.idx));
                chk("mon_last", int'(ifc.last), int'(e.last));
                chk("mon_remaining", int'(ifc.remaining), int'(e.rem));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int xfer0;
        bit done;

        reset          = 1'b1;
        ifc.load_valid = 1'b0;
        ifc.load_vec   = '0;
        ifc.idx_ready  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk_idle("rst");
        chk("rst_remaining", int'(ifc.remaining), 0);
        chk("rst_idx", int'(ifc.idx), 0);
        chk("rst_last", int'(ifc.last), 0);

        // Basic sequence 0,2,5,31 at full throughput.
        push(0, 0, 4);
        push(2, 0, 3);
        push(5, 0, 2);
        push(31, 1, 1);
        ifc.idx_ready  = 1'b1;
        ifc.load_valid = 1'b1;
        ifc.load_vec   = 32'h8000_0025;
        tick();
        ifc.load_valid = 1'b0;
        chk("basic_latency_valid", int'(ifc.idx_valid), 1);
        chk("basic_load_ready_low", int'(ifc.load_ready), 0);
        chk("basic_busy", int'(ifc.busy), 1);
        repeat (4) tick();
        chk_idle("basic_end");
        chk("basic_queue", exp_q.size(), 0);

        // Backpressure: payload held stable while idx_ready is low.
        ifc.idx_ready  = 1'b0;
        ifc.load_valid = 1'b1;
        ifc.load_vec   = 32'h0000_0003;
        tick();
        ifc.load_valid = 1'b0;
        repeat (3) begin
            chk("bp_valid", int'(ifc.idx_valid), 1);
            chk("bp_idx", int'(ifc.idx), 0);
            chk("bp_remaining", int'(ifc.remaining), 2);
            chk("bp_last", int'(ifc.last), 0);
            tick();
        end
        push(0, 0, 2);
        push(1, 1, 1);
        ifc.idx_ready = 1'b1;
        tick();
        tick();
        chk_idle("bp_end");

        // Zero vector is swallowed.
        ifc.load_valid = 1'b1;
        ifc.load_vec   = 32'h0;
        tick();
        ifc.load_valid = 1'b0;
        repeat (4) begin
            chk("zero_valid", int'(ifc.idx_valid), 0);
            chk("zero_busy", int'(ifc.busy), 0);
            tick();
        end

        // Loads offered during EMIT are ignored.
        ifc.idx_ready  = 1'b0;
        ifc.load_valid = 1'b1;
        ifc.load_vec   = 32'h0000_0100;
        tick();
        ifc.load_vec = 32'h0000_0001;
        repeat (3) begin
            chk("ign_idx", int'(ifc.idx), 8);
            chk("ign_remaining", int'(ifc.remaining), 1);
            tick();
        end
        ifc.load_valid = 1'b0;
        push(8, 1, 1);
        ifc.idx_ready = 1'b1;
        tick();
        repeat (3) begin
            chk_idle("ign_end");
            tick();
        end

        // Full vector with random backpressure.
        ifc.idx_ready  = 1'b0;
        ifc.load_valid = 1'b1;
        ifc.load_vec   = 32'hFFFF_FFFF;
        tick();
        ifc.load_valid = 1'b0;
        chk("full_remaining_start", int'(ifc.remaining), 32);
        chk("full_first_idx", int'(ifc.idx), 0);
        for (int i = 0; i < 32; i++) push(i, (i == 31), 32 - i);
        xfer0 = n_xfer;
        done  = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            ifc.idx_ready = 1'($urandom_range(0, 1));
            tick();
            if (!ifc.idx_valid) done = 1'b1;
        end
        chk("full_drained", int'(done), 1);
        chk("full_xfers", n_xfer - xfer0, 32);
        chk("full_queue", exp_q.size(), 0);

        // Back-to-back single-bit vectors with one idle bubble.
        push(4, 1, 1);
        push(30, 1, 1);
        ifc.idx_ready  = 1'b1;
        ifc.load_valid = 1'b1;
        ifc.load_vec   = 32'h0000_0010;
        tick();
        ifc.load_vec = 32'h4000_0000;
        chk("b2b_first_idx", int'(ifc.idx), 4);
        chk("b2b_first_last", int'(ifc.last), 1);
        tick();
        chk_idle("b2b_bubble");
        tick();
        ifc.load_valid = 1'b0;
        chk("b2b_second_idx", int'(ifc.idx), 30);
        chk("b2b_second_last", int'(ifc.last), 1);
        tick();
        chk_idle("b2b_end");

        // Single bit 31 is last on its first cycle.
        push(31, 1, 1);
        ifc.load_valid = 1'b1;
        ifc.load_vec   = 32'h8000_0000;
        tick();
        ifc.load_valid = 1'b0;
        chk("bit31_idx", int'(ifc.idx), 31);
        tick();
        chk_idle("bit31_end");

        // Reset during EMIT beats a simultaneous handshake.
        ifc.idx_ready  = 1'b0;
        ifc.load_valid = 1'b1;
        ifc.load_vec   = 32'hFFFF_FFFF;
        tick();
        ifc.load_valid = 1'b0;
        reset          = 1'b1;
        ifc.idx_ready  = 1'b1;
        tick();
        tick();
        reset         = 1'b0;
        ifc.idx_ready = 1'b0;
        chk_idle("midrst");
        chk("midrst_remaining", int'(ifc.remaining), 0);
        chk("midrst_idx", int'(ifc.idx), 0);
        chk("midrst_last", int'(ifc.last), 0);
        ifc.idx_ready = 1'b1;
        tick();
        chk("midrst_discarded", int'(ifc.idx_valid), 0);
        chk("final_queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
